// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MDU state encoding,
// the register-zero constant and default latencies.
package pipe_ctrl_pkg;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned DEF_MULT_CYCLES = 4;
  localparam int unsigned DEF_DIV_CYCLES  = 32;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned MDU_CNT_W       = 6;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath (master) and the
// stall/flush scheduler (slave).
interface pipe_hazard_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_mdu_start;
  logic             id_mdu_is_div;
  logic             id_reads_hilo;
  logic             ex_memread;
  logic [4:0]       ex_wdst;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             mdu_busy;
  logic             mdu_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_start, id_mdu_is_div,
           id_reads_hilo, ex_memread, ex_wdst, ex_branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, mdu_busy, mdu_done, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_start, id_mdu_is_div,
           id_reads_hilo, ex_memread, ex_wdst, ex_branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, mdu_busy, mdu_done, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_mdu_sched.sv
// MULT/DIV occupancy tracker: loads the unit latency on acceptance, counts
// down every cycle (freezes included) and pulses done on the way out.
module mdu_sched import pipe_ctrl_pkg::*; #(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [MDU_CNT_W-1:0] MULT_LOAD = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_LOAD  = MDU_CNT_W'(DIV_CYCLES);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE   = MDU_CNT_W'(1);

  mdu_state_e           state;
  logic [MDU_CNT_W-1:0] mdu_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MDU_IDLE;
      mdu_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (accept) begin
            mdu_cnt <= is_div ? DIV_LOAD : MULT_LOAD;
            state   <= MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          if (mdu_cnt == CNT_ONE) begin
            mdu_cnt <= '0;
            state   <= MDU_IDLE;
            done    <= 1'b1;
          end else begin
            mdu_cnt <= mdu_cnt - CNT_ONE;
          end
        end
        default: begin
          state   <= MDU_IDLE;
          mdu_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: priority decode of memory
// wait, branch squash, load-use and MDU hazards, plus a stall-cycle counter.
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; #(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  logic             lu;
  logic             mh;
  logic             mw;
  logic             mdu_accept;
  logic             mdu_busy;
  logic             mdu_done;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic [CNT_W-1:0] stall_cnt;

  always_comb begin
    lu = bus.ex_memread && (bus.ex_wdst != REG_ZERO) &&
         ((bus.id_uses_rs && (bus.id_rs == bus.ex_wdst)) ||
          (bus.id_uses_rt && (bus.id_rt == bus.ex_wdst)));
    mh = mdu_busy && (bus.id_mdu_start || bus.id_reads_hilo);
    mw = bus.mem_req && !bus.mem_ready;
  end

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    mdu_accept  = 1'b0;
    if (!rst) begin
      if (mw) begin
        // full freeze: everything already at zero
      end else if (bus.ex_branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else if (lu || mh) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        // a stalled ID instruction is re-presented, so only run accepts
        mdu_accept  = bus.id_mdu_start;
      end
    end
  end

  mdu_sched #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_sched (
    .clk    (clk),
    .rst    (rst),
    .accept (mdu_accept),
    .is_div (bus.id_mdu_is_div),
    .busy   (mdu_busy),
    .done   (mdu_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.mem_wb_en   = mem_wb_en;
  assign bus.mdu_busy    = mdu_busy;
  assign bus.mdu_done    = mdu_done;
  assign bus.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second narrow-counter instance
// held in permanent memory wait exercises counter saturation.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] S_OFF = 7'b0000000;
  localparam logic [6:0] S_RUN = 7'b1101011;
  localparam logic [6:0] S_LU  = 7'b0001111;
  localparam logic [6:0] S_BR  = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(3))  sat_bus ();

  pipe_hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(3)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_bus)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic [6:0] exp);
    check(tag, {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
                bus.id_ex_flush, bus.ex_mem_en, bus.mem_wb_en}, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_mdu_start = 1'b0; bus.id_mdu_is_div = 1'b0; bus.id_reads_hilo = 1'b0;
    bus.ex_memread = 1'b0; bus.ex_wdst = '0; bus.ex_branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  initial begin
    sat_bus.id_rs = '0; sat_bus.id_rt = '0; sat_bus.id_uses_rs = 1'b0; sat_bus.id_uses_rt = 1'b0;
    sat_bus.id_mdu_start = 1'b0; sat_bus.id_mdu_is_div = 1'b0; sat_bus.id_reads_hilo = 1'b0;
    sat_bus.ex_memread = 1'b0; sat_bus.ex_wdst = '0; sat_bus.ex_branch_taken = 1'b0;
    sat_bus.mem_req = 1'b1; sat_bus.mem_ready = 1'b0;
  end

  initial begin
    int unsigned done_seen;
    clear_inputs();
    #2;
    chk_strobes("rst_strobes", S_OFF);
    check("rst_busy", bus.mdu_busy, 0);
    check("rst_done", bus.mdu_done, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);

    step();
    rst = 1'b0;
    #1;
    chk_strobes("run_idle", S_RUN);
    step(); step(); step();
    check("sat_cnt_3", sat_bus.stall_cnt, 3);
    check("run_stall_cnt", bus.stall_cnt, 0);

    // load-use on rs
    bus.ex_memread = 1'b1; bus.ex_wdst = 5'd8; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd8;
    #1;
    chk_strobes("lu_rs", S_LU);
    step();
    check("lu_rs_cnt", bus.stall_cnt, 1);
    bus.ex_memread = 1'b0;
    #1;
    chk_strobes("lu_release", S_RUN);
    step();
    check("lu_release_cnt", bus.stall_cnt, 1);

    // load-use on rt
    clear_inputs();
    bus.ex_memread = 1'b1; bus.ex_wdst = 5'd9; bus.id_uses_rt = 1'b1; bus.id_rt = 5'd9;
    #1;
    chk_strobes("lu_rt", S_LU);
    step();
    check("lu_rt_cnt", bus.stall_cnt, 2);
    bus.id_uses_rt = 1'b0;
    #1;
    chk_strobes("rt_unused", S_RUN);
    step();

    // destination r0 never stalls
    clear_inputs();
    bus.ex_memread = 1'b1; bus.ex_wdst = 5'd0; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd0;
    #1;
    chk_strobes("wdst_zero", S_RUN);
    step();
    check("wdst_zero_cnt", bus.stall_cnt, 2);

    // branch beats load-use and squashes an MDU start
    clear_inputs();
    bus.ex_memread = 1'b1; bus.ex_wdst = 5'd8; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd8;
    bus.ex_branch_taken = 1'b1; bus.id_mdu_start = 1'b1;
    #1;
    chk_strobes("branch_over_lu", S_BR);
    step();
    check("branch_cnt", bus.stall_cnt, 2);
    check("branch_no_accept", bus.mdu_busy, 0);

    clear_inputs();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    #1;
    chk_strobes("mem_ready_same", S_RUN);
    step();
    check("mem_ready_cnt", bus.stall_cnt, 2);

    // divide with mflo waiting in ID
    clear_inputs();
    bus.id_mdu_start = 1'b1; bus.id_mdu_is_div = 1'b1;
    #1;
    chk_strobes("div_accept", S_RUN);
    step();
    bus.id_mdu_start = 1'b0; bus.id_mdu_is_div = 1'b0; bus.id_reads_hilo = 1'b1;
    #1;
    for (int c = 1; c <= 32; c++) begin
      check($sformatf("div_busy_c%0d", c), bus.mdu_busy, 1);
      check($sformatf("div_done_c%0d", c), bus.mdu_done, 0);
      chk_strobes($sformatf("div_mflo_c%0d", c), S_LU);
      step();
    end
    check("div_c33_busy", bus.mdu_busy, 0);
    check("div_c33_done", bus.mdu_done, 1);
    chk_strobes("div_c33_mflo_runs", S_RUN);
    check("div_stall_cnt", bus.stall_cnt, 34);
    step();
    check("div_done_once", bus.mdu_done, 0);

    // multiply with a 3-cycle memory freeze
    clear_inputs();
    bus.id_mdu_start = 1'b1;
    #1;
    step();
    bus.id_mdu_start = 1'b0; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    #1;
    for (int c = 1; c <= 3; c++) begin
      chk_strobes($sformatf("freeze_c%0d", c), S_OFF);
      check($sformatf("freeze_busy_c%0d", c), bus.mdu_busy, 1);
      step();
    end
    bus.mem_req = 1'b0;
    #1;
    check("mult_c4_busy", bus.mdu_busy, 1);
    chk_strobes("mult_c4_run", S_RUN);
    step();
    check("mult_c5_busy", bus.mdu_busy, 0);
    check("mult_c5_done", bus.mdu_done, 1);
    check("freeze_stall_cnt", bus.stall_cnt, 37);

    // branch while busy: flush proceeds, MDU keeps counting
    clear_inputs();
    bus.id_mdu_start = 1'b1;
    #1;
    step();
    bus.id_mdu_start = 1'b0; bus.ex_branch_taken = 1'b1;
    #1;
    chk_strobes("branch_busy", S_BR);
    step();
    bus.ex_branch_taken = 1'b0;
    step(); step();
    check("branch_busy_c4", bus.mdu_busy, 1);
    step();
    check("branch_busy_done", bus.mdu_done, 1);
    check("branch_busy_cnt", bus.stall_cnt, 37);
    check("sat_cnt_max", sat_bus.stall_cnt, 7);

    // asynchronous reset mid-divide
    clear_inputs();
    bus.id_mdu_start = 1'b1; bus.id_mdu_is_div = 1'b1;
    #1;
    step();
    bus.id_mdu_start = 1'b0; bus.id_mdu_is_div = 1'b0;
    for (int c = 2; c <= 10; c++) step();
    check("pre_rst_busy", bus.mdu_busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_busy", bus.mdu_busy, 0);
    check("async_rst_cnt", bus.stall_cnt, 0);
    check("async_rst_sat_cnt", sat_bus.stall_cnt, 0);
    chk_strobes("async_rst_strobes", S_OFF);
    step();
    rst = 1'b0;
    #1;
    chk_strobes("post_rst_run", S_RUN);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.mdu_done) done_seen++;
      step();
    end
    check("post_rst_no_done", done_seen, 0);
    check("post_rst_busy", bus.mdu_busy, 0);
    check("post_rst_cnt", bus.stall_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
